// File: rtl/note_mem_arb.sv
// Note memory arbiter: shares one synchronous note RAM between the UART
// loader (writes) and playback (reads), and tracks the recorded song length.
module note_mem_arb #(
    parameter int AW = 16,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_en,
    output logic          wr_ack,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_ack,
    output logic [DW-1:0] rd_data,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          clr_len,
    output logic [AW:0]   song_len,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RD_WAIT,
        S_RD_DONE
    } state_t;

    localparam logic GRANT_RD = 1'b0;
    localparam logic GRANT_WR = 1'b1;

    state_t        state_q;
    logic          last_grant_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          wr_ack_q;
    logic          rd_ack_q;
    logic [DW-1:0] rd_data_q;
    logic [AW:0]   song_len_q;
    logic [AW:0]   song_len_d;
    logic          busy_q;

    logic          wr_elig;
    logic          grant_wr;
    logic          grant_rd;
    logic          enter_wr;
    logic [AW:0]   wr_len;
    logic [AW:0]   len_max;

    // On a tie the side that did not win last time gets the RAM.
    always_comb begin
        wr_elig  = wr_req & wr_en;
        grant_wr = wr_elig & (~rd_req | (last_grant_q == GRANT_RD));
        grant_rd = rd_req & ~grant_wr;
        enter_wr = (state_q == S_IDLE) & grant_wr;
    end

    // Length is one past the highest written address, kept in AW+1 bits.
    always_comb begin
        wr_len     = {1'b0, wr_addr} + {{AW{1'b0}}, 1'b1};
        len_max    = (wr_len > song_len_q) ? wr_len : song_len_q;
        song_len_d = song_len_q;
        if (enter_wr) begin
            song_len_d = clr_len ? wr_len : len_max;
        end else if (clr_len) begin
            song_len_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= GRANT_WR;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            wr_ack_q     <= 1'b0;
            rd_ack_q     <= 1'b0;
            rd_data_q    <= '0;
            song_len_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            song_len_q <= song_len_d;
            unique case (state_q)
                S_IDLE: begin
                    if (grant_wr) begin
                        state_q      <= S_WR;
                        last_grant_q <= GRANT_WR;
                        mem_we_q     <= 1'b1;
                        mem_addr_q   <= wr_addr;
                        mem_wdata_q  <= wr_data;
                        wr_ack_q     <= 1'b1;
                        busy_q       <= 1'b1;
                    end else if (grant_rd) begin
                        state_q      <= S_RD;
                        last_grant_q <= GRANT_RD;
                        mem_we_q     <= 1'b0;
                        mem_addr_q   <= rd_addr;
                        busy_q       <= 1'b1;
                    end
                end
                S_WR: begin
                    state_q  <= S_IDLE;
                    mem_we_q <= 1'b0;
                    wr_ack_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
                S_RD: begin
                    state_q <= S_RD_WAIT;
                end
                // RAM output for the address issued in RD is valid here.
                S_RD_WAIT: begin
                    state_q   <= S_RD_DONE;
                    rd_data_q <= mem_rdata;
                    rd_ack_q  <= 1'b1;
                end
                S_RD_DONE: begin
                    state_q  <= S_IDLE;
                    rd_ack_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
                default: begin
                    state_q  <= S_IDLE;
                    mem_we_q <= 1'b0;
                    wr_ack_q <= 1'b0;
                    rd_ack_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wr_ack    = wr_ack_q;
    assign rd_ack    = rd_ack_q;
    assign rd_data   = rd_data_q;
    assign song_len  = song_len_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_note_mem_arb.sv
// Bench for note_mem_arb: cycle table of directed vectors plus hand
// sequences for round-robin order, wr_en drop and reset during a read.
module tb_note_mem_arb;

    localparam int AW = 16;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_en = 1'b0;
    logic          wr_ack;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_ack;
    logic [DW-1:0] rd_data;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          clr_len = 1'b0;
    logic [AW:0]   song_len;
    logic          busy;

    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;
    logic [DW-1:0] ram [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    note_mem_arb #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_en(wr_en), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_ack(rd_ack), .rd_data(rd_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .clr_len(clr_len),
        .song_len(song_len), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM model with a bench-side preload port.
    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic        wreq, wen;
        logic [15:0] waddr;
        logic [11:0] wdata;
        logic        rreq;
        logic [15:0] raddr;
        logic        clr;
        logic        e_wack, e_rack, e_we;
        logic [15:0] e_addr;
        logic [11:0] e_wdata;
        logic        e_busy;
        logic [16:0] e_len;
        logic [11:0] e_rdata;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(
        input logic wreq, input logic wen, input logic [15:0] waddr,
        input logic [11:0] wdata, input logic rreq, input logic [15:0] raddr,
        input logic clr, input logic e_wack, input logic e_rack,
        input logic e_we, input logic [15:0] e_addr, input logic [11:0] e_wdata,
        input logic e_busy, input logic [16:0] e_len, input logic [11:0] e_rdata);
        vec_t v;
        v.wreq = wreq; v.wen = wen; v.waddr = waddr; v.wdata = wdata;
        v.rreq = rreq; v.raddr = raddr; v.clr = clr;
        v.e_wack = e_wack; v.e_rack = e_rack; v.e_we = e_we;
        v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_busy = e_busy;
        v.e_len = e_len; v.e_rdata = e_rdata;
        return v;
    endfunction

    function automatic logic [63:0] outs();
        return {3'b0, wr_ack, rd_ack, mem_we, mem_addr, mem_wdata,
                busy, song_len, rd_data};
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        string order;
        int n;
        int racks;
        //             wreq wen waddr    wdata   rreq raddr clr | wack rack we addr     wdata   busy len       rdata
        vecs[0]  = mk(1, 1, 16'h0005, 12'h3A7, 0, 16'h0, 0, 1, 0, 1, 16'h0005, 12'h3A7, 1, 17'h00006, 12'h000);
        vecs[1]  = mk(0, 1, 16'h0005, 12'h3A7, 0, 16'h0, 0, 0, 0, 0, 16'h0005, 12'h3A7, 0, 17'h00006, 12'h000);
        vecs[2]  = mk(0, 0, 16'h0000, 12'h000, 1, 16'h9, 0, 0, 0, 0, 16'h0009, 12'h3A7, 1, 17'h00006, 12'h000);
        vecs[3]  = mk(0, 0, 16'h0000, 12'h000, 1, 16'h9, 0, 0, 0, 0, 16'h0009, 12'h3A7, 1, 17'h00006, 12'h000);
        vecs[4]  = mk(0, 0, 16'h0000, 12'h000, 1, 16'h9, 0, 0, 1, 0, 16'h0009, 12'h3A7, 1, 17'h00006, 12'h155);
        vecs[5]  = mk(0, 0, 16'h0000, 12'h000, 0, 16'h0, 0, 0, 0, 0, 16'h0009, 12'h3A7, 0, 17'h00006, 12'h155);
        vecs[6]  = mk(1, 0, 16'h0007, 12'h111, 0, 16'h0, 0, 0, 0, 0, 16'h0009, 12'h3A7, 0, 17'h00006, 12'h155);
        vecs[7]  = mk(1, 0, 16'h0007, 12'h111, 0, 16'h0, 0, 0, 0, 0, 16'h0009, 12'h3A7, 0, 17'h00006, 12'h155);
        vecs[8]  = mk(1, 0, 16'h0007, 12'h111, 1, 16'h5, 0, 0, 0, 0, 16'h0005, 12'h3A7, 1, 17'h00006, 12'h155);
        vecs[9]  = mk(1, 0, 16'h0007, 12'h111, 1, 16'h5, 0, 0, 0, 0, 16'h0005, 12'h3A7, 1, 17'h00006, 12'h155);
        vecs[10] = mk(1, 0, 16'h0007, 12'h111, 1, 16'h5, 0, 0, 1, 0, 16'h0005, 12'h3A7, 1, 17'h00006, 12'h3A7);
        vecs[11] = mk(1, 0, 16'h0007, 12'h111, 0, 16'h0, 0, 0, 0, 0, 16'h0005, 12'h3A7, 0, 17'h00006, 12'h3A7);
        vecs[12] = mk(1, 1, 16'hFFFF, 12'h0AB, 0, 16'h0, 0, 1, 0, 1, 16'hFFFF, 12'h0AB, 1, 17'h10000, 12'h3A7);
        vecs[13] = mk(0, 1, 16'hFFFF, 12'h0AB, 0, 16'h0, 0, 0, 0, 0, 16'hFFFF, 12'h0AB, 0, 17'h10000, 12'h3A7);
        vecs[14] = mk(1, 1, 16'h0003, 12'h001, 0, 16'h0, 0, 1, 0, 1, 16'h0003, 12'h001, 1, 17'h10000, 12'h3A7);
        vecs[15] = mk(0, 1, 16'h0003, 12'h001, 0, 16'h0, 0, 0, 0, 0, 16'h0003, 12'h001, 0, 17'h10000, 12'h3A7);
        vecs[16] = mk(1, 1, 16'h0003, 12'h002, 0, 16'h0, 1, 1, 0, 1, 16'h0003, 12'h002, 1, 17'h00004, 12'h3A7);
        vecs[17] = mk(0, 1, 16'h0003, 12'h002, 0, 16'h0, 0, 0, 0, 0, 16'h0003, 12'h002, 0, 17'h00004, 12'h3A7);
        vecs[18] = mk(0, 1, 16'h0003, 12'h002, 0, 16'h0, 1, 0, 0, 0, 16'h0003, 12'h002, 0, 17'h00000, 12'h3A7);
        vecs[19] = mk(0, 1, 16'h0003, 12'h002, 0, 16'h0, 0, 0, 0, 0, 16'h0003, 12'h002, 0, 17'h00000, 12'h3A7);

        // Reset asserted mid-cycle, with no clock edge yet.
        #2 rst = 1'b1;
        #1 check("reset_state", outs(), 64'h0);

        pre_we = 1'b1; pre_addr = 16'h9; pre_data = 12'h155;
        step();
        pre_we = 1'b0;
        step();
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            wr_req  = vecs[i].wreq;  wr_en   = vecs[i].wen;
            wr_addr = vecs[i].waddr; wr_data = vecs[i].wdata;
            rd_req  = vecs[i].rreq;  rd_addr = vecs[i].raddr;
            clr_len = vecs[i].clr;
            step();
            check($sformatf("row%0d", i), outs(),
                  {3'b0, vecs[i].e_wack, vecs[i].e_rack, vecs[i].e_we,
                   vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_busy,
                   vecs[i].e_len, vecs[i].e_rdata});
        end
        clr_len = 1'b0; wr_req = 1'b0; rd_req = 1'b0;

        // Both requesters held from reset release: read wins the first tie.
        rst = 1'b1;
        step();
        wr_req = 1'b1; wr_en = 1'b1; wr_addr = 16'd20; wr_data = 12'h0C1;
        rd_req = 1'b1; rd_addr = 16'h9;
        rst = 1'b0;
        order = "";
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            step();
            if (wr_ack && rd_ack) order = {order, "B"};
            if (wr_ack) begin
                order = {order, "W"};
                n++;
                wr_addr = wr_addr + 16'd1;
                wr_data = wr_data + 12'd1;
            end else if (rd_ack) begin
                order = {order, "R"};
                n++;
            end
        end
        wr_req = 1'b0; rd_req = 1'b0;
        checks++;
        if (order != "RWRW") begin
            errors++;
            $display("FAIL grant_order: got '%s' expected 'RWRW'", order);
        end
        step();
        step();
        check("rr_len", {47'b0, song_len}, 64'd22);

        // Dropping wr_en while in WR must not cancel the write.
        wr_req = 1'b1; wr_en = 1'b1; wr_addr = 16'h40; wr_data = 12'h5A5;
        step();
        check("wen_drop_ack", {62'b0, wr_ack, mem_we}, 64'b11);
        wr_en = 1'b0; wr_req = 1'b0;
        step();
        check("wen_drop_ram", {52'b0, ram[16'h40]}, 64'h5A5);
        check("wen_drop_len", {47'b0, song_len}, 64'h41);

        // Reset during RD_WAIT abandons the read.
        rd_req = 1'b1; rd_addr = 16'h40;
        step();
        step();
        check("rdwait_busy", {63'b0, busy}, 64'd1);
        #2 rst = 1'b1;
        #1 check("rdwait_reset", outs(), 64'h0);
        rd_req = 1'b0;
        step();
        rst = 1'b0;
        racks = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (rd_ack) racks++;
        end
        check("no_ack_after_rst", 64'(racks), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/note_mem_arb.md
NOTE_MEM_ARB -- requirements
Module: note_mem_arb

Interface
REQ-001 SHALL have parameter AW, default 16, note memory address width.
REQ-002 SHALL have parameter DW, default 12, note word width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have ports wr_req / wr_addr / wr_data, input, 1 / AW / DW, write requester (UART loader): request, address, note word.
REQ-006 SHALL have port wr_en, input, 1, writes permitted (write mode selected).
REQ-007 SHALL have port wr_ack, output, 1, one-cycle pulse: write issued.
REQ-008 SHALL have ports rd_req / rd_addr, input, 1 / AW, read requester (playback): request, address.
REQ-009 SHALL have ports rd_ack / rd_data, output, 1 / DW, one-cycle pulse with the returned note word.
REQ-010 SHALL have ports mem_we / mem_addr / mem_wdata, output, 1 / AW / DW, single-port synchronous note RAM controls, all registered.
REQ-011 SHALL have port mem_rdata, input, DW, RAM read data, valid one clock after address edge.
REQ-012 SHALL have port clr_len, input, 1, clear recorded song length.
REQ-013 SHALL have ports song_len / busy, output, AW+1 / 1, highest written address plus one; state not IDLE.

Function
REQ-014 SHALL implement states IDLE, WR, RD, RD_WAIT, RD_DONE; only IDLE samples requests.
REQ-015 Eligible write SHALL be wr_req=1 and wr_en=1; wr_req with wr_en=0 SHALL be ignored, no ack, no RAM write.
REQ-016 IDLE, only write eligible -> WR; only rd_req -> RD; neither -> stay IDLE.
REQ-017 IDLE, both eligible -> grant the side opposite to last_grant (round-robin); last_grant updated on each grant.
REQ-018 Entering WR SHALL register mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, wr_ack=1; WR -> IDLE next edge with mem_we=0, wr_ack=0.
REQ-019 Entering RD SHALL register mem_addr=rd_addr, mem_we=0; RD -> RD_WAIT -> RD_DONE on successive edges.
REQ-020 Entering RD_DONE SHALL register rd_data=mem_rdata and rd_ack=1; RD_DONE -> IDLE next edge, rd_ack=0.
REQ-021 Latency: write ack 1 cycle after request sampled; read ack 3 cycles after request sampled; at least one non-IDLE cycle follows every ack so a requester may drop or change req on the edge it sees ack.
REQ-022 Requesters SHALL hold req/addr/data stable until ack; arbiter does not latch unaccepted requests.
REQ-023 rd_data SHALL hold its last value between reads.
REQ-024 On WR entry, song_len SHALL become max(song_len, wr_addr+1) computed in AW+1 bits (wr_addr all ones -> 2^AW, no wrap).
REQ-025 clr_len SHALL set song_len=0 in any state; clr_len in the same cycle as WR entry SHALL yield song_len=wr_addr+1.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 wr_en falling during WR SHALL not abort the issued write.

Reset
REQ-028 rst=1 SHALL force state=IDLE, last_grant=write, mem_we=0, mem_addr=0, mem_wdata=0, wr_ack=0, rd_ack=0, rd_data=0, song_len=0, busy=0 immediately, independent of clk.
REQ-029 Reset mid-access SHALL abandon the access with no ack; first grant after release is read on a tie.

Verification
REQ-030 wr_en=1, wr_req addr=5 data=0x3A7 -> next cycle mem_we=1, mem_addr=5, mem_wdata=0x3A7, wr_ack=1; song_len=6.
REQ-031 RAM preloaded addr 9=0x155, rd_req addr=9 -> rd_ack=1 with rd_data=0x155 exactly 3 cycles after sample; mem_we stays 0.
REQ-032 Both requests held from reset release with acks honoured -> grant order read, write, read, write; no double ack per request.
REQ-033 wr_req with wr_en=0 for 10 cycles -> no wr_ack, mem_we never 1, song_len unchanged; concurrent rd_req served normally.
REQ-034 Writes to addr 0xFFFF then 3 -> song_len=0x10000 both times; clr_len with write addr 3 same cycle -> song_len=4.
REQ-035 rst asserted in RD_WAIT -> outputs at reset values immediately, no rd_ack after release until a new rd_req.
